clk_prog_ctrl: RTL and testbench

//  Serial programmer driving the DCM_CLKGEN PROG port (progen/progdata/progclk) of
//  the programmable clock blocks. Sits in the IFCLK domain next to the host command

---
 rtl/clk_prog_ctrl_if.sv | 40 ++++
 rtl/clk_prog_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_clk_prog_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_prog_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_prog_ctrl_if
//  Description : Bundle of the host-side command/status signals and the
//                DCM_CLKGEN PROG port signals of the clock programmer.
//                master = host/clock side, slave = clk_prog_ctrl.
//  Ports       : start, cmt_sel[1:0], m_val[7:0], d_val[7:0]  (host -> ctrl)
//                busy, done, err                              (ctrl -> host)
//                progen[N_CMT-1:0], progdata, progclk,
//                pll_reset                                    (ctrl -> clocks)
//                progdone_inv                                 (clocks -> ctrl)
//  Revision    : 1.0  initial release
// ============================================================================
interface clk_prog_ctrl_if #(
  parameter int N_CMT = 4
);
  logic             start;
  logic [1:0]       cmt_sel;
  logic [7:0]       m_val;
  logic [7:0]       d_val;
  logic             busy;
  logic             done;
  logic             err;
  logic [N_CMT-1:0] progen;
  logic             progdata;
  logic             progclk;
  logic             progdone_inv;
  logic             pll_reset;

  modport master (
    output start, cmt_sel, m_val, d_val, progdone_inv,
    input  busy, done, err, progen, progdata, progclk, pll_reset
  );

  modport slave (
    input  start, cmt_sel, m_val, d_val, progdone_inv,
    output busy, done, err, progen, progdata, progclk, pll_reset
  );
endinterface
`default_nettype wire

// File: rtl/clk_prog_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_prog_ctrl
//  Description : Serial programmer for the DCM_CLKGEN PROG port. Shifts LoadD,
//                LoadM and GO commands to the selected CMT, waits for
//                PROGDONE, then pulses pll_reset so the downstream PLL relocks.
//  Ports       : IFCLK  - sole clock
//                reset  - asynchronous active-high reset
//                bus    - clk_prog_ctrl_if.slave (command, status, PROG port)
//  Revision    : 1.0  initial release
// ============================================================================
module clk_prog_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int N_CMT       = 4,
  parameter int TIMEOUT     = 65535,
  parameter int PLL_RST_LEN = 16
) (
  input  logic           IFCLK,
  input  logic           reset,
  clk_prog_ctrl_if.slave bus
);
  localparam int SLOT = 2 * CLK_DIV;
  localparam int PW   = $clog2(SLOT);
  localparam int CW   = $clog2(TIMEOUT + PLL_RST_LEN + 1);

  localparam logic [PW-1:0] PH_LAST   = PW'(SLOT - 1);
  localparam logic [PW-1:0] PH_HIGH   = PW'(CLK_DIV);
  // Earliest WAIT_DONE cycle that may exit: two full slots after GO.
  localparam logic [CW-1:0] WAIT_MIN  = CW'(2 * SLOT - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_D    = 3'd1,
    S_GAP1      = 3'd2,
    S_LOAD_M    = 3'd3,
    S_GAP2      = 3'd4,
    S_GO        = 3'd5,
    S_WAIT_DONE = 3'd6,
    S_PLL_RST   = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;      // cycle within the current bit slot
  logic [3:0]       bit_q, bit_d;          // slot index within the current state
  logic [CW-1:0]    cnt_q, cnt_d;          // WAIT_DONE / PLL_RST cycle counter
  logic [1:0]       sel_q, sel_d;
  logic [7:0]       dv_q, dv_d;            // D-1
  logic [7:0]       mv_q, mv_d;            // M-1
  logic [2:0]       sync_q, sync_d;        // [1] = synchronised, [2] = one cycle older
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [N_CMT-1:0] progen_q, progen_d;
  logic             progdata_q, progdata_d;
  logic             progclk_q, progclk_d;
  logic             pll_reset_q, pll_reset_d;

  logic             slot_end;
  logic             args_bad;
  logic             done_seen;
  logic [9:0]       load_d_word;
  logic [9:0]       load_m_word;

  assign slot_end    = (phase_q == PH_LAST);
  assign args_bad    = (bus.m_val < 8'd2) || (bus.d_val == 8'd0) ||
                       (int'(bus.cmt_sel) >= N_CMT);
  // PROGDONE (active low) must be seen on two consecutive synchronised samples.
  assign done_seen   = !sync_q[1] && !sync_q[2];
  // Command words, LSB transmitted first: 2-bit opcode then the 8-bit value.
  assign load_d_word = {dv_d, 2'b01};
  assign load_m_word = {mv_d, 2'b11};

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    dv_d    = dv_q;
    mv_d    = mv_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sync_d  = {sync_q[1:0], bus.progdone_inv};

    // progclk keeps running through WAIT_DONE, so the slot phase does too.
    if (state_q != S_IDLE && state_q != S_PLL_RST) begin
      phase_d = slot_end ? '0 : phase_q + PW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sel_d = bus.cmt_sel;
          dv_d  = bus.d_val - 8'd1;
          mv_d  = bus.m_val - 8'd1;
          if (args_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = S_LOAD_D;
            phase_d = '0;
            bit_d   = '0;
          end
        end
      end
      S_LOAD_D: if (slot_end) begin
        if (bit_q == 4'd9) begin state_d = S_GAP1; bit_d = '0; end
        else bit_d = bit_q + 4'd1;
      end
      S_GAP1: if (slot_end) begin
        if (bit_q == 4'd1) begin state_d = S_LOAD_M; bit_d = '0; end
        else bit_d = bit_q + 4'd1;
      end
      S_LOAD_M: if (slot_end) begin
        if (bit_q == 4'd9) begin state_d = S_GAP2; bit_d = '0; end
        else bit_d = bit_q + 4'd1;
      end
      S_GAP2: if (slot_end) begin
        if (bit_q == 4'd1) begin state_d = S_GO; bit_d = '0; end
        else bit_d = bit_q + 4'd1;
      end
      S_GO: if (slot_end) begin
        state_d = S_WAIT_DONE;
        cnt_d   = '0;
      end
      S_WAIT_DONE: begin
        if (done_seen && cnt_q >= WAIT_MIN) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PLL_RST: begin
        if (cnt_q == PLL_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next-state values so every PROG pin
    // changes exactly at a slot boundary and is glitch free.
    busy_d      = (state_d != S_IDLE);
    pll_reset_d = (state_d == S_PLL_RST);
    progclk_d   = 1'b0;
    if (state_d inside {S_LOAD_D, S_GAP1, S_LOAD_M, S_GAP2, S_GO, S_WAIT_DONE}) begin
      progclk_d = (phase_d >= PH_HIGH);
    end
    progen_d = '0;
    if (state_d inside {S_LOAD_D, S_LOAD_M, S_GO}) begin
      progen_d = N_CMT'(1) << sel_d;
    end
    progdata_d = 1'b0;
    if (state_d == S_LOAD_D) progdata_d = load_d_word[bit_d];
    if (state_d == S_LOAD_M) progdata_d = load_m_word[bit_d];
  end

  always_ff @(posedge IFCLK or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      dv_q        <= '0;
      mv_q        <= '0;
      sync_q      <= 3'b111;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      progen_q    <= '0;
      progdata_q  <= 1'b0;
      progclk_q   <= 1'b0;
      pll_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      dv_q        <= dv_d;
      mv_q        <= mv_d;
      sync_q      <= sync_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      progen_q    <= progen_d;
      progdata_q  <= progdata_d;
      progclk_q   <= progclk_d;
      pll_reset_q <= pll_reset_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.progen    = progen_q;
  assign bus.progdata  = progdata_q;
  assign bus.progclk   = progclk_q;
  assign bus.pll_reset = pll_reset_q;
endmodule
`default_nettype wire

// File: tb/tb_clk_prog_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_prog_ctrl
//  Description : Self-checking bench for clk_prog_ctrl: timeline model of the
//                PROG protocol compared every cycle, plus literal checks of
//                transmitted frames, latencies and abort behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clk_prog_ctrl;
  localparam int CLK_DIV     = 2;
  localparam int N_CMT       = 4;
  localparam int TIMEOUT     = 65535;
  localparam int PLL_RST_LEN = 16;
  localparam int SLOT        = 2 * CLK_DIV;

  logic IFCLK = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  clk_prog_ctrl_if #(.N_CMT(N_CMT)) bus ();
  clk_prog_ctrl_if #(.N_CMT(3))     bus3 ();

  clk_prog_ctrl #(.CLK_DIV(CLK_DIV), .N_CMT(N_CMT), .TIMEOUT(TIMEOUT),
                  .PLL_RST_LEN(PLL_RST_LEN)) u_dut (
    .IFCLK(IFCLK), .reset(reset), .bus(bus));

  // Small instance with only 3 CMTs so an out-of-range cmt_sel is expressible.
  clk_prog_ctrl #(.CLK_DIV(1), .N_CMT(3), .TIMEOUT(40), .PLL_RST_LEN(4)) u_dut3 (
    .IFCLK(IFCLK), .reset(reset), .bus(bus3));

  always #5 IFCLK = ~IFCLK;
  always @(posedge IFCLK) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model (timeline of the protocol) -----------
  int   m_ph = 0;                   // 0 idle, 1 shifting, 2 waiting, 3 pll reset
  int   m_n, m_w, m_p, m_sel;
  bit   m_ena [25];
  bit   m_dat [25];
  bit   h1 = 1'b1, h2 = 1'b1, h3 = 1'b1;   // progdone_inv at edges k-1,k-2,k-3
  bit   e_done, e_err, m_busy, m_data, m_clk, m_pll;
  logic [N_CMT-1:0] m_en;
  logic [7:0] m_dv, m_mv;
  logic [N_CMT+5:0] exp_v = '0;

  initial forever begin
    @(posedge IFCLK or posedge reset);
    if (reset) begin
      m_ph = 0; h1 = 1'b1; h2 = 1'b1; h3 = 1'b1; exp_v = '0;
    end else begin
      e_done = 1'b0; e_err = 1'b0;
      case (m_ph)
        0: if (bus.start) begin
          if (bus.m_val < 2 || bus.d_val == 0 || int'(bus.cmt_sel) >= N_CMT) e_err = 1'b1;
          else begin
            m_dv = bus.d_val - 8'd1; m_mv = bus.m_val - 8'd1; m_sel = int'(bus.cmt_sel);
            for (int s = 0; s < 25; s++) begin m_ena[s] = 1'b0; m_dat[s] = 1'b0; end
            for (int s = 0; s < 10; s++) begin m_ena[s] = 1'b1; m_ena[12+s] = 1'b1; end
            m_ena[24] = 1'b1;
            m_dat[0] = 1'b1; m_dat[12] = 1'b1; m_dat[13] = 1'b1;
            for (int b = 0; b < 8; b++) begin m_dat[2+b] = m_dv[b]; m_dat[14+b] = m_mv[b]; end
            m_ph = 1; m_n = 0;
          end
        end
        1: begin
          m_n++;
          if (m_n == 25 * SLOT) begin m_ph = 2; m_w = 0; end
        end
        2: begin
          if (m_w >= 2 * SLOT - 1 && !h2 && !h3) begin m_ph = 3; m_p = 0; end
          else if (m_w == TIMEOUT - 1) begin e_err = 1'b1; m_ph = 0; end
          else m_w++;
        end
        default: begin
          m_p++;
          if (m_p == PLL_RST_LEN) begin e_done = 1'b1; m_ph = 0; end
        end
      endcase
      h3 = h2; h2 = h1; h1 = bus.progdone_inv;
      m_busy = 1'b0; m_en = '0; m_data = 1'b0; m_clk = 1'b0; m_pll = 1'b0;
      if (m_ph == 1) begin
        m_busy = 1'b1;
        m_clk  = (m_n % SLOT) >= CLK_DIV;
        if (m_ena[m_n / SLOT]) m_en = N_CMT'(1) << m_sel;
        m_data = m_dat[m_n / SLOT];
      end else if (m_ph == 2) begin
        m_busy = 1'b1;
        m_clk  = (m_w % SLOT) >= CLK_DIV;
      end else if (m_ph == 3) begin
        m_busy = 1'b1; m_pll = 1'b1;
      end
      exp_v = {m_busy, e_done, e_err, m_en, m_data, m_clk, m_pll};
    end
  end

  // ---------------- compare + capture process ------------------------------
  logic [N_CMT:0] cap_q [$];
  bit prev_clk = 1'b0;
  int pll_cycles = 0;
  int en_cycles  = 0;

  initial forever begin
    @(negedge IFCLK);
    if (reset) prev_clk = 1'b0;
    else begin
      check("cycle_outputs", {bus.busy, bus.done, bus.err, bus.progen, bus.progdata,
                              bus.progclk, bus.pll_reset}, exp_v);
      if (bus.progclk && !prev_clk && bus.progen != '0) cap_q.push_back({bus.progen, bus.progdata});
      prev_clk = bus.progclk;
      if (bus.pll_reset) pll_cycles++;
      if (bus.progen != '0) en_cycles++;
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  int t_start;

  task automatic pulse_start(int sel, int m, int d);
    @(negedge IFCLK);
    bus.start = 1'b1; bus.cmt_sel = sel[1:0]; bus.m_val = m[7:0]; bus.d_val = d[7:0];
    @(negedge IFCLK);
    bus.start = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_end(int bound, output int t, output bit was_done);
    t = -1; was_done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (bus.done || bus.err) begin t = cyc; was_done = bus.done; break; end
      @(negedge IFCLK);
    end
  endtask

  task automatic check_frame(string name, input bit e[21], input logic [N_CMT-1:0] en);
    logic [20:0] ev, cv;
    logic [N_CMT-1:0] en_or;
    ev = '0; cv = '0; en_or = '0;
    for (int i = 0; i < 21; i++) ev[i] = e[i];
    for (int i = 0; i < cap_q.size() && i < 21; i++) begin
      cv[i] = cap_q[i][0];
      en_or = en_or | cap_q[i][N_CMT:1];
    end
    check({name, "_nbits"}, cap_q.size(), 21);
    check({name, "_bits"}, cv, ev);
    check({name, "_progen"}, en_or, en);
  endtask

  // ---------------- directed tests -----------------------------------------
  int t;
  bit wd;
  int c0;
  bit f_t1 [21] = '{1,0,0,1,0,0,0,0,0,0, 1,1,0,1,1,0,0,0,0,0, 0};
  bit f_b  [21] = '{1,0,0,0,0,0,0,0,0,0, 1,1,1,0,0,0,0,0,0,0, 0};
  bit f_t5 [21] = '{1,0,0,1,1,1,1,1,1,1, 1,1,0,1,1,1,1,1,1,1, 0};
  bit f_t4 [21] = '{1,0,0,0,1,0,0,0,0,0, 1,1,1,0,0,1,0,0,0,0, 0};

  initial begin
    bus.start = 1'b0; bus.cmt_sel = '0; bus.m_val = '0; bus.d_val = '0; bus.progdone_inv = 1'b1;
    bus3.start = 1'b0; bus3.cmt_sel = '0; bus3.m_val = '0; bus3.d_val = '0; bus3.progdone_inv = 1'b1;
    repeat (3) @(negedge IFCLK);
    check("reset_outputs", {bus.busy, bus.done, bus.err, bus.progen, bus.progdata,
                            bus.progclk, bus.pll_reset}, '0);
    reset = 1'b0;
    repeat (2) @(negedge IFCLK);

    // T1: sel 0, M=7, D=3
    cap_q.delete(); pll_cycles = 0; en_cycles = 0;
    pulse_start(0, 7, 3);
    check("t1_busy", bus.busy, 1);
    bus.progdone_inv = 1'b0;
    wait_end(300, t, wd);
    check("t1_done", wd, 1);
    check("t1_latency", t - t_start, 124);
    check("t1_pll_cycles", pll_cycles, 16);
    check("t1_progen_cycles", en_cycles, 84);
    check_frame("t1", f_t1, 4'b0001);
    bus.progdone_inv = 1'b1;
    repeat (3) @(negedge IFCLK);

    // T2: argument errors
    pulse_start(0, 1, 3);
    check("t2_m1_err", bus.err, 1);
    check("t2_m1_idle", {bus.busy, bus.progen, bus.progclk}, 0);
    @(negedge IFCLK);
    check("t2_m1_err_pulse", bus.err, 0);
    pulse_start(1, 7, 0);
    check("t2_d0_err", bus.err, 1);
    check("t2_d0_idle", {bus.busy, bus.progen, bus.progclk}, 0);
    @(negedge IFCLK);
    bus3.start = 1'b1; bus3.cmt_sel = 2'd3; bus3.m_val = 8'd7; bus3.d_val = 8'd3;
    @(negedge IFCLK);
    bus3.start = 1'b0;
    check("t2_sel3_err", bus3.err, 1);
    check("t2_sel3_idle", {bus3.busy, bus3.progen, bus3.progclk}, 0);
    repeat (4) @(negedge IFCLK);
    check("t2_sel3_quiet", {bus3.busy, bus3.err, bus3.progen, bus3.progclk}, 0);

    // Boundary: smallest legal M and D
    cap_q.delete();
    bus.progdone_inv = 1'b0;
    pulse_start(1, 2, 1);
    wait_end(300, t, wd);
    check("tb_min_done", wd, 1);
    check("tb_min_latency", t - t_start, 124);
    check_frame("tb_min", f_b, 4'b0010);
    bus.progdone_inv = 1'b1;
    repeat (3) @(negedge IFCLK);

    // T5: sel 3, M=D=255, second start while busy ignored
    cap_q.delete();
    pulse_start(3, 255, 255);
    c0 = t_start;
    repeat (10) @(negedge IFCLK);
    pulse_start(0, 7, 3);
    bus.progdone_inv = 1'b0;
    wait_end(300, t, wd);
    check("t5_done", wd, 1);
    check("t5_latency", t - c0, 124);
    check_frame("t5", f_t5, 4'b1000);
    bus.progdone_inv = 1'b1;
    repeat (3) @(negedge IFCLK);

    // T6: one-cycle low glitch on progdone_inv is rejected
    pulse_start(0, 7, 3);
    repeat (112) @(negedge IFCLK);
    bus.progdone_inv = 1'b0;
    @(negedge IFCLK);
    bus.progdone_inv = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge IFCLK);
      check("t6_glitch_no_pll", bus.pll_reset, 0);
    end
    bus.progdone_inv = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge IFCLK);
      if (bus.pll_reset) break;
    end
    check("t6_exit_delay", cyc - c0, 4);
    wait_end(40, t, wd);
    check("t6_done", wd, 1);
    bus.progdone_inv = 1'b1;
    repeat (3) @(negedge IFCLK);

    // T4: asynchronous reset during LOAD_M, then a clean run
    pulse_start(2, 10, 5);
    repeat (60) @(negedge IFCLK);
    check("t4_pre_reset_progen", bus.progen, 4'b0100);
    #1 reset = 1'b1;
    #1 check("t4_reset_async", {bus.busy, bus.done, bus.err, bus.progen, bus.progdata,
                                bus.progclk, bus.pll_reset}, '0);
    @(negedge IFCLK);
    reset = 1'b0;
    repeat (2) @(negedge IFCLK);
    cap_q.delete();
    bus.progdone_inv = 1'b0;
    pulse_start(2, 10, 5);
    wait_end(300, t, wd);
    check("t4_done", wd, 1);
    check("t4_latency", t - t_start, 124);
    check_frame("t4", f_t4, 4'b0100);
    bus.progdone_inv = 1'b1;
    repeat (3) @(negedge IFCLK);

    // T3: PROGDONE never arrives -> timeout error, no pll_reset
    pll_cycles = 0;
    pulse_start(0, 7, 3);
    wait_end(70000, t, wd);
    check("t3_err_seen", (t >= 0) && !wd && bus.err, 1);
    check("t3_latency", t - t_start, 65635);
    check("t3_no_pll", pll_cycles, 0);
    repeat (3) @(negedge IFCLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
